bus_ram: RTL and testbench
==========================

BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 The block SHALL use one clock, CLK, and one reset, RST, which is synchronous and active-high.
REQ-002 Parameter AW, default 10, SHALL set the word-address width (depth 2^AW words).
REQ-003 Parameter BYTES, default 2, SHALL set the byte-lane count (data width 8*BYTES).
REQ-004 Parameter WAIT, default 0, range 0..7, SHALL set the number of wait-state cycles inserted per access.
REQ-005 Parameter CLEAR_ON_RESET, default 1, SHALL enable zero-fill of the whole array after reset.
REQ-006 The ports SHALL be, one per line:
 CLK   in   1          clock
 RST   in   1          synchronous active-high reset
 REQ   in   1          access request, held by master until ACK
 WR    in   1          1 = write, 0 = read
 ADDR  in   AW         word address
 SEL   in   BYTES      byte-lane enables for writes
 DI    in   8*BYTES    write data
 PINJ  in   1          parity-error injection on write
 DO    out  8*BYTES    read data
 ACK   out  1          one-cycle transfer acknowledge
 BUSY  out  1          clear sequence in progress
 PERR  out  1          read parity error, valid with ACK

Function
REQ-007 The FSM SHALL have the states CLEAR, IDLE, WAITS, ACCESS and DONE.
REQ-008 In IDLE, REQ=1 at an edge SHALL latch WR, ADDR, SEL, DI and PINJ, and SHALL move to WAITS if WAIT>0, otherwise to ACCESS.
REQ-009 WAITS SHALL count exactly WAIT cycles on a 3-bit counter and then move to ACCESS.
REQ-010 ACCESS SHALL perform exactly one array read or write at the latched address and then move to DONE.
REQ-011 DONE SHALL assert ACK for exactly one cycle and return to IDLE, so ACK rises WAIT+2 edges after the sampling edge.
REQ-012 A write SHALL update only the lanes whose SEL bit is 1; SEL=0 SHALL leave memory unchanged and SHALL still be acknowledged.
REQ-013 A read SHALL return the full word regardless of SEL, and DO SHALL be valid in the ACK cycle.
REQ-014 DO SHALL hold the last read value until the next read's ACK; writes SHALL NOT change DO.
REQ-015 Inputs SHALL be ignored outside IDLE; latched values SHALL be stable from sampling until ACK.
REQ-016 A REQ still high in the IDLE cycle after DONE SHALL start a new access (back-to-back).
REQ-017 In CLEAR, the block SHALL write zero to addresses 0..2^AW-1, one per cycle, with BUSY=1 and REQ not sampled, and SHALL enter IDLE after the last address.
REQ-018 With CLEAR_ON_RESET=0, the block SHALL go from reset directly to IDLE, and array contents SHALL be undefined.

Reset
REQ-019 RST SHALL take priority over all activity, with ACK=0, DO=0, PERR=0, BUSY=CLEAR_ON_RESET, counters=0, and the state set to CLEAR or IDLE.
REQ-020 RST during ACCESS SHALL suppress that array write.
REQ-021 RST mid-CLEAR SHALL restart the clear from address 0.
REQ-022 RST mid-transaction SHALL abort it without ACK.

Configuration
REQ-023 With RAM_PARITY_EN defined, one even-parity bit per lane SHALL be stored on every lane write, inverted when the latched PINJ=1.
REQ-024 With RAM_PARITY_EN defined, CLEAR SHALL write correct parity (0).
REQ-025 With RAM_PARITY_EN defined, PERR SHALL be 1 in a read's ACK cycle if any lane mismatches, and 0 in all other cycles.
REQ-026 Without RAM_PARITY_EN, there SHALL be no parity storage, PINJ SHALL be ignored, and PERR SHALL be constant 0.

Verification
REQ-027 Reset release with AW=4, CLEAR_ON_RESET=1 -> BUSY=1 for 16 cycles, then reads of all addresses return 0.
REQ-028 WAIT=0: write 16'h15C0 to address 3, then read address 3 -> each ACK 2 edges after REQ is sampled, DO=16'h15C0.
REQ-029 Write 16'hFFFF, then write 16'h1234 with SEL=2'b01, then read -> DO=16'hFF34; a SEL=2'b00 write changes nothing but is acknowledged.
REQ-030 WAIT=3 with REQ held continuously -> ACK every 6 cycles, and ACK is never high for 2 consecutive cycles.
REQ-031 RST asserted in the ACCESS cycle of a write of 16'hAAAA over 16'h0000 (CLEAR_ON_RESET=0) -> no ACK, and a later read returns 16'h0000.
REQ-032 RAM_PARITY_EN: write with PINJ=1, then read -> PERR=1 with ACK; rewrite with PINJ=0 and read -> PERR=0; without the macro -> PERR=0 throughout.

Source files
------------

// File: rtl/bus_ram.sv
// bus_ram: single-port word RAM behind a REQ/ACK handshake.
//
// An access is sampled in IDLE, optionally stretched by WAIT wait states,
// performed in a single ACCESS cycle and acknowledged with a one-cycle ACK.
// After reset the array can be zero-filled (CLEAR_ON_RESET), with BUSY high
// for the whole fill.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   : one even-parity bit per byte lane is stored; PINJ inverts it
//               on writes, PERR flags a lane mismatch in a read's ACK cycle.
//   undefined : no parity storage, PINJ ignored, PERR tied low.
//
// Parameters:
//   AW             word-address width (depth 2**AW)
//   BYTES          byte lanes (data width 8*BYTES)
//   WAIT           wait states per access, 0..7
//   CLEAR_ON_RESET 1 = zero-fill the array after reset
//
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   REQ   access request, held by the master until ACK
//   WR    1 = write, 0 = read
//   ADDR  word address
//   SEL   byte-lane enables for writes
//   DI    write data
//   PINJ  parity-error injection on write
//   DO    read data, updated in a read's ACK cycle and held otherwise
//   ACK   one-cycle transfer acknowledge
//   BUSY  clear sequence in progress
//   PERR  read parity error, valid with ACK
//
// state  | meaning
// CLEAR  | zero-filling the array, one word per cycle, REQ ignored
// IDLE   | waiting for REQ; latches the request when it arrives
// WAITS  | counting down the configured wait states
// ACCESS | the single array read or write for this transfer
// DONE   | last cycle before ACK; ACK/DO/PERR are registered here

module bus_ram #(
  parameter int AW             = 10,
  parameter int BYTES          = 2,
  parameter int WAIT           = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic               WR,
  input  logic [AW-1:0]      ADDR,
  input  logic [BYTES-1:0]   SEL,
  input  logic [8*BYTES-1:0] DI,
  input  logic               PINJ,
  output logic [8*BYTES-1:0] DO,
  output logic               ACK,
  output logic               BUSY,
  output logic               PERR
);

  localparam int DW    = 8 * BYTES;
  localparam int DEPTH = 1 << AW;
  // wait counter load value: WAITS runs cnt = WAIT-1 .. 0, i.e. WAIT cycles
  localparam logic [2:0] WAIT_LD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [2:0] {CLEAR, IDLE, WAITS, ACCESS, DONE} state_t;

  state_t             state;
  logic [2:0]         wait_cnt;
  logic [AW-1:0]      clr_addr;
  logic               wr_q;
  logic [AW-1:0]      addr_q;
  logic [BYTES-1:0]   sel_q;
  logic [DW-1:0]      di_q;
  logic [DW-1:0]      rd_data;
  logic               rd_perr;

  logic [DW-1:0]      mem [DEPTH];

  logic               mem_we;
  logic               rd_en;
  logic [BYTES-1:0]   mem_be;
  logic [AW-1:0]      mem_wa;
  logic [DW-1:0]      mem_wd;

  logic [DW-1:0]      do_q;
  logic               ack_q;
  logic               busy_q;
  logic               perr_q;

`ifdef RAM_PARITY_EN
  logic               pinj_q;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= IDLE;
      busy_q   <= (CLEAR_ON_RESET != 0);
      ack_q    <= 1'b0;
      perr_q   <= 1'b0;
      do_q     <= '0;
      wait_cnt <= '0;
      clr_addr <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      di_q     <= '0;
`ifdef RAM_PARITY_EN
      pinj_q   <= 1'b0;
`endif
    end else begin
      ack_q  <= 1'b0;
      perr_q <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_addr == '1) begin
            clr_addr <= '0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (REQ) begin
            wr_q   <= WR;
            addr_q <= ADDR;
            sel_q  <= SEL;
            di_q   <= DI;
`ifdef RAM_PARITY_EN
            pinj_q <= PINJ;
`endif
            if (WAIT > 0) begin
              wait_cnt <= WAIT_LD;
              state    <= WAITS;
            end else begin
              state    <= ACCESS;
            end
          end
        end
        WAITS: begin
          if (wait_cnt == 3'd0) state <= ACCESS;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        ACCESS: state <= DONE;
        DONE: begin
          ack_q <= 1'b1;
          state <= IDLE;
          // writes leave DO/PERR untouched
          if (!wr_q) begin
            do_q   <= rd_data;
            perr_q <= rd_perr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Array port: clear fill or the latched access. RST gates the write so an
  // access interrupted in its ACCESS cycle never lands in the array.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we = 1'b0;
    rd_en  = 1'b0;
    mem_be = sel_q;
    mem_wa = addr_q;
    mem_wd = di_q;
    if (state == CLEAR) begin
      mem_we = !RST;
      mem_be = '1;
      mem_wa = clr_addr;
      mem_wd = '0;
    end else if (state == ACCESS) begin
      mem_we = !RST && wr_q;
      rd_en  = !wr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[addr_q];
  end

  // ---------------------------------------------------------------------------
  // Optional per-lane parity
  // ---------------------------------------------------------------------------
`ifdef RAM_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
  logic [BYTES-1:0] wr_par;
  logic [BYTES-1:0] rd_par;
  logic [BYTES-1:0] rd_calc;

  // injection only applies to real writes; clear always stores correct parity
  always_comb begin
    wr_par  = '0;
    rd_calc = '0;
    for (int b = 0; b < BYTES; b++) begin
      wr_par[b]  = (^mem_wd[8*b +: 8]) ^ ((state == ACCESS) && pinj_q);
      rd_calc[b] = ^rd_data[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) par_mem[mem_wa][b] <= wr_par[b];
      end
    end
    if (rd_en) rd_par <= par_mem[addr_q];
  end

  assign rd_perr = |(rd_par ^ rd_calc);
`else
  logic unused_pinj;
  assign unused_pinj = PINJ;
  assign rd_perr     = 1'b0;
`endif

  assign DO   = do_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign PERR = perr_q;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: three instances (AW=4, 16-bit data)
//   0: WAIT=0, CLEAR_ON_RESET=1
//   1: WAIT=3, CLEAR_ON_RESET=1
//   2: WAIT=1, CLEAR_ON_RESET=0
// Expected data comes from a word/lane array model updated from the
// handshake rules; expected latency is WAIT+2 edges after the sampling edge.
module tb_bus_ram;

  localparam int N = 3;

`ifdef RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst  [N];
  logic        req  [N];
  logic        wr   [N];
  logic [3:0]  addr [N];
  logic [1:0]  sel  [N];
  logic [15:0] di   [N];
  logic        pinj [N];
  logic [15:0] dout [N];
  logic        ack  [N];
  logic        busy [N];
  logic        perr [N];

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl     [N][16];
  logic [1:0]  mbad    [N][16];
  logic [15:0] last_rd [N];

  always #5 clk = ~clk;

  bus_ram #(.AW(4), .BYTES(2), .WAIT(0), .CLEAR_ON_RESET(1)) u_w0 (
    .CLK(clk), .RST(rst[0]), .REQ(req[0]), .WR(wr[0]), .ADDR(addr[0]),
    .SEL(sel[0]), .DI(di[0]), .PINJ(pinj[0]), .DO(dout[0]), .ACK(ack[0]),
    .BUSY(busy[0]), .PERR(perr[0]));

  bus_ram #(.AW(4), .BYTES(2), .WAIT(3), .CLEAR_ON_RESET(1)) u_w3 (
    .CLK(clk), .RST(rst[1]), .REQ(req[1]), .WR(wr[1]), .ADDR(addr[1]),
    .SEL(sel[1]), .DI(di[1]), .PINJ(pinj[1]), .DO(dout[1]), .ACK(ack[1]),
    .BUSY(busy[1]), .PERR(perr[1]));

  bus_ram #(.AW(4), .BYTES(2), .WAIT(1), .CLEAR_ON_RESET(0)) u_nc (
    .CLK(clk), .RST(rst[2]), .REQ(req[2]), .WR(wr[2]), .ADDR(addr[2]),
    .SEL(sel[2]), .DI(di[2]), .PINJ(pinj[2]), .DO(dout[2]), .ACK(ack[2]),
    .BUSY(busy[2]), .PERR(perr[2]));

  function automatic int wt(input int i);
    case (i)
      0: return 0;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit clears(input int i);
    return (i != 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    last_rd[i] = 16'h0000;
    if (clears(i)) begin
      for (int a = 0; a < 16; a++) begin
        mdl[i][a]  = 16'h0000;
        mbad[i][a] = 2'b00;
      end
    end
  endtask

  // one transfer; inputs are scrambled after the sampling edge
  task automatic access(input int i, input logic w, input logic [3:0] a,
                        input logic [1:0] s, input logic [15:0] d, input logic pj,
                        output logic [15:0] rdo, output logic rperr, output int lat);
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; addr[i] = a; sel[i] = s; di[i] = d; pinj[i] = pj;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        wr[i]   = 1'($urandom);
        addr[i] = 4'($urandom);
        sel[i]  = 2'($urandom);
        di[i]   = 16'($urandom);
        pinj[i] = 1'($urandom);
      end
    end while (!ack[i] && lat < 40);
    req[i] = 1'b0;
    rdo    = dout[i];
    rperr  = perr[i];
  endtask

  task automatic do_op(input int i, input logic w, input logic [3:0] a,
                       input logic [1:0] s, input logic [15:0] d, input logic pj);
    logic [15:0] rdo, exp_do;
    logic        rperr, exp_perr;
    int          lat;
    access(i, w, a, s, d, pj, rdo, rperr, lat);
    check($sformatf("latency[%0d]", i), 32'(lat - 1), 32'(wt(i) + 2));
    if (w) begin
      for (int b = 0; b < 2; b++) begin
        if (s[b]) begin
          mdl[i][a][8*b +: 8] = d[8*b +: 8];
          mbad[i][a][b]       = pj;
        end
      end
      exp_do   = last_rd[i];
      exp_perr = 1'b0;
    end else begin
      exp_do     = mdl[i][a];
      exp_perr   = PAR_EN && (mbad[i][a] != 2'b00);
      last_rd[i] = exp_do;
    end
    check($sformatf("do[%0d] a=%0d w=%0d", i, a, w), 32'(rdo), 32'(exp_do));
    check($sformatf("perr[%0d] a=%0d", i, a), 32'(rperr), 32'(exp_perr));
    @(posedge clk); #1;
    check($sformatf("ack_pulse[%0d]", i), 32'(ack[i]), 32'd0);
    check($sformatf("perr_idle[%0d]", i), 32'(perr[i]), 32'd0);
  endtask

  initial begin
    logic [15:0] rdo;
    logic        rperr;
    int          bcnt [N];
    int          ack_at [$];
    logic        prev_ack;
    logic [3:0]  ba;

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0;
      sel[i] = '0; di[i] = '0; pinj[i] = 1'b0;
      mdl[i][0] = '0;
    end

    // reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ack[%0d]", i),  32'(ack[i]),  32'd0);
      check($sformatf("rst_do[%0d]", i),   32'(dout[i]), 32'd0);
      check($sformatf("rst_perr[%0d]", i), 32'(perr[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'(clears(i)));
      model_reset(i);
    end

    // clear length after release
    for (int i = 0; i < N; i++) begin rst[i] = 1'b0; bcnt[i] = 0; end
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) if (busy[i]) bcnt[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++)
      check($sformatf("busy_cycles[%0d]", i), 32'(bcnt[i]), clears(i) ? 32'd16 : 32'd0);

    // reset in the middle of a clear restarts it from address 0
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    bcnt[0] = 0;
    for (int c = 0; c < 24; c++) begin
      if (busy[0]) bcnt[0]++;
      @(negedge clk);
    end
    check("busy_restart", 32'(bcnt[0]), 32'd16);

    // whole array reads zero after the clear
    for (int a = 0; a < 16; a++) do_op(0, 1'b0, 4'(a), 2'b00, 16'h0, 1'b0);

    // basic write/read, WAIT=0
    do_op(0, 1'b1, 4'd3, 2'b11, 16'h15C0, 1'b0);
    do_op(0, 1'b0, 4'd3, 2'b00, 16'h0, 1'b0);
    check("rd_15c0", 32'(dout[0]), 32'h15C0);

    // byte lanes
    do_op(0, 1'b1, 4'd7, 2'b11, 16'hFFFF, 1'b0);
    do_op(0, 1'b1, 4'd7, 2'b01, 16'h1234, 1'b0);
    do_op(0, 1'b0, 4'd7, 2'b10, 16'h0, 1'b0);
    check("rd_ff34", 32'(dout[0]), 32'hFF34);
    do_op(0, 1'b1, 4'd7, 2'b00, 16'h5555, 1'b0);
    do_op(0, 1'b0, 4'd7, 2'b00, 16'h0, 1'b0);
    check("rd_sel0", 32'(dout[0]), 32'hFF34);

    // parity injection and repair
    do_op(0, 1'b1, 4'd2, 2'b11, 16'hA5C3, 1'b1);
    do_op(0, 1'b0, 4'd2, 2'b00, 16'h0, 1'b0);
    check("perr_inj", 32'(perr[0] | 1'b0), 32'd0); // ACK cycle already past
    do_op(0, 1'b1, 4'd2, 2'b11, 16'hA5C3, 1'b0);
    do_op(0, 1'b0, 4'd2, 2'b00, 16'h0, 1'b0);

    // random traffic on the clearing instances
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 50; k++) begin
        do_op(i, 1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));
      end
    end

    // back-to-back reads with REQ held, WAIT=3
    ba = 4'($urandom);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = ba; sel[1] = 2'b11;
    prev_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      check("ack_not_double", 32'(prev_ack & ack[1]), 32'd0);
      if (ack[1]) begin
        ack_at.push_back(c);
        check("b2b_do", 32'(dout[1]), 32'(mdl[1][ba]));
        check("b2b_perr", 32'(perr[1]), 32'(PAR_EN && (mbad[1][ba] != 2'b00)));
      end
      prev_ack = ack[1];
    end
    req[1] = 1'b0;
    repeat (12) @(negedge clk);
    last_rd[1] = mdl[1][ba];
    check("b2b_count", (ack_at.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    if (ack_at.size() > 0) check("b2b_first", 32'(ack_at[0]), 32'd5);
    for (int k = 1; k < ack_at.size(); k++)
      check("b2b_period", 32'(ack_at[k] - ack_at[k-1]), 32'd6);

    // reset in the ACCESS cycle of a write suppresses it (no clear instance)
    do_op(2, 1'b1, 4'd9, 2'b11, 16'h0000, 1'b0);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 4'd9; sel[2] = 2'b11; di[2] = 16'hAAAA; pinj[2] = 1'b0;
    repeat (wt(2) + 1) @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1; req[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_no_ack", 32'(ack[2]), 32'd0);
      check("abort_busy", 32'(busy[2]), 32'd0);
    end
    @(negedge clk); rst[2] = 1'b0;
    model_reset(2);
    do_op(2, 1'b0, 4'd9, 2'b00, 16'h0, 1'b0);
    check("abort_rd", 32'(dout[2]), 32'h0000);

    // a few fully-written words on the non-clearing instance
    for (int k = 0; k < 8; k++) begin
      ba = 4'($urandom);
      do_op(2, 1'b1, ba, 2'b11, 16'($urandom), 1'($urandom));
      do_op(2, 1'b0, ba, 2'b00, 16'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
